// File: rtl/riscv_trace_capture.sv
// riscv_trace_capture: tags writeback and data-memory trace events
// and streams them out through a dual-push FIFO with drop accounting.
module riscv_trace_capture #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic                       clear,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_type,
  output logic [ADDR_W-1:0]          out_tag,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2 + ADDR_W + DATA_W;
  localparam logic [CW:0] DEP = (CW+1)'(DEPTH);

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              r_ev;
  logic              m_ev;
  logic [EW-1:0]     r_ent;
  logic [EW-1:0]     m_ent;
  logic [EW-1:0]     e0;
  logic [EW-1:0]     head;
  logic              pop;
  logic [CW:0]       space;
  logic [1:0]        push_n;
  logic [1:0]        drop_n;
  logic [DROP_W:0]   dsum;
  logic [DROP_W-1:0] drop_nxt;

  assign r_ev = trace_en & reg_write_sig
              & (reg_num != 5'd0);
  assign m_ev = trace_en & (wr | rd);

  assign r_ent = {2'b01,
                  ADDR_W'(reg_num),
                  reg_data};
  assign m_ent = wr ? {2'b10, addr, wr_data}
                    : {2'b11, addr, rd_data};
  assign e0    = r_ev ? r_ent : m_ent;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign space     = DEP - {1'b0, count}
                   + (CW+1)'(pop);

  // Decide how many events fit; R always wins the last free slot.
  always_comb begin
    push_n = 2'd0;
    drop_n = 2'd0;
    unique case (1'b1)
      r_ev & m_ev: begin
        if (space >= (CW+1)'(2)) begin
          push_n = 2'd2;
        end else if (space == (CW+1)'(1)) begin
          push_n = 2'd1;
          drop_n = 2'd1;
        end else begin
          drop_n = 2'd2;
        end
      end
      r_ev ^ m_ev: begin
        if (space != '0) push_n = 2'd1;
        else             drop_n = 2'd1;
      end
      default: ;
    endcase
  end

  assign dsum = {1'b0, drop_cnt}
              + (DROP_W+1)'(drop_n);
  assign drop_nxt = dsum[DROP_W] ? '1
                                 : dsum[DROP_W-1:0];

  // Pointer, occupancy and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rd_ptr   <= rd_ptr + PW'(pop);
      wr_ptr   <= wr_ptr + PW'(push_n);
      count    <= count + CW'(push_n)
                - CW'(pop);
      if (drop_n != 2'd0) overflow <= 1'b1;
      drop_cnt <= drop_nxt;
    end
  end

  // Entry storage; a double push may straddle the wrap point.
  always_ff @(posedge clk) begin
    if (!reset && !clear) begin
      if (push_n != 2'd0)
        mem[wr_ptr] <= e0;
      if (push_n == 2'd2)
        mem[wr_ptr + PW'(1)] <= m_ent;
    end
  end

  assign head = mem[rd_ptr];

  assign out_type = out_valid
                  ? head[EW-1 -: 2] : '0;
  assign out_tag  = out_valid
                  ? head[DATA_W +: ADDR_W] : '0;
  assign out_data = out_valid
                  ? head[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_riscv_trace_capture.sv
// tb_riscv_trace_capture: directed stimulus with a queue scoreboard
// checked by an independent output monitor.
module tb_riscv_trace_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en;
  logic        clear;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr;
  logic        rd;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_type;
  logic [8:0]  out_tag;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        overflow;
  logic [3:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [42:0] q[$];

  always #5 clk = ~clk;

  riscv_trace_capture #(
    .DATA_W(32), .ADDR_W(9),
    .DEPTH(16), .DROP_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .trace_en(trace_en), .clear(clear),
    .reg_write_sig(reg_write_sig),
    .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_type(out_type), .out_tag(out_tag),
    .out_data(out_data), .count(count),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               nm, got, exp);
    end
  endtask

  // Monitor: every accepted head beat must match the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got=%h exp=none",
                 {out_type, out_tag, out_data});
      end else begin
        if ({out_type, out_tag, out_data} !== q[0]) begin
          failures++;
          $display("FAIL pop_head got=%h exp=%h",
                   {out_type, out_tag, out_data}, q[0]);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic exp_e(input logic [1:0] t,
                       input logic [8:0] g,
                       input logic [31:0] d);
    q.push_back({t, g, d});
  endtask

  task automatic ev(input logic rw,
                    input logic [4:0] rn,
                    input logic [31:0] rdat,
                    input logic w,
                    input logic r,
                    input logic [8:0] a,
                    input logic [31:0] wd,
                    input logic [31:0] ld,
                    input logic rdy);
    reg_write_sig = rw;
    reg_num = rn;
    reg_data = rdat;
    wr = w;
    rd = r;
    addr = a;
    wr_data = wd;
    rd_data = ld;
    out_ready = rdy;
    @(posedge clk);
    #1;
    reg_write_sig = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    out_ready = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    ev(0, 5'd0, 0, 0, 0, 9'd0, 0, 0, rdy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) idle(1'b1);
  endtask

  initial begin
    reset = 1'b1;
    trace_en = 1'b1;
    clear = 1'b0;
    reg_write_sig = 1'b0;
    reg_num = '0;
    reg_data = '0;
    wr = 1'b0;
    rd = 1'b0;
    addr = '0;
    wr_data = '0;
    rd_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_type", 64'(out_type), 0);
    chk("rst_tag", 64'(out_tag), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_drop", 64'(drop_cnt), 0);

    // single register write
    exp_e(2'b01, 9'd5, 32'hDEADBEEF);
    ev(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    chk("r1_count", 64'(count), 1);
    chk("r1_valid", 64'(out_valid), 1);
    chk("r1_type", 64'(out_type), 1);
    chk("r1_tag", 64'(out_tag), 5);
    chk("r1_data", 64'(out_data), 64'hDEADBEEF);
    idle(1'b0);
    chk("r1_hold", 64'(out_data), 64'hDEADBEEF);
    trace_en = 1'b0;
    ev(1, 5'd7, 32'h7, 1, 0, 9'd3, 32'h9, 0, 0);
    trace_en = 1'b1;
    chk("te_off_count", 64'(count), 1);
    drain(1);
    chk("r1_drained", 64'(count), 0);
    ev(1, 5'd0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    chk("x0_count", 64'(count), 0);
    chk("x0_drop", 64'(drop_cnt), 0);

    // same-cycle ordering: R before M
    exp_e(2'b01, 9'd3, 32'h11);
    exp_e(2'b10, 9'h1F0, 32'h22);
    ev(1, 5'd3, 32'h11, 1, 0, 9'h1F0, 32'h22, 0, 0);
    chk("rm_count", 64'(count), 2);
    drain(2);

    // load capture, then write/read conflict
    exp_e(2'b11, 9'h004, 32'hCAFE0001);
    ev(0, 0, 0, 0, 1, 9'h004, 0, 32'hCAFE0001, 0);
    chk("ld_type", 64'(out_type), 3);
    drain(1);
    exp_e(2'b10, 9'h008, 32'h33);
    ev(0, 0, 0, 1, 1, 9'h008, 32'h33, 32'h44, 0);
    chk("wrrd_count", 64'(count), 1);
    drain(1);
    chk("wrrd_drained", 64'(count), 0);

    // fill 15, then R+M: R fits, M dropped
    for (int i = 0; i < 15; i++) begin
      exp_e(2'b01, 9'(i + 1), 32'(i));
      ev(1, 5'(i + 1), 32'(i), 0, 0, 0, 0, 0, 0);
    end
    chk("fill15_count", 64'(count), 15);
    exp_e(2'b01, 9'd20, 32'hAA);
    ev(1, 5'd20, 32'hAA, 1, 0, 9'h10, 32'hBB, 0, 0);
    chk("full_count", 64'(count), 16);
    chk("full_ovf", 64'(overflow), 1);
    chk("full_drop1", 64'(drop_cnt), 1);
    ev(1, 5'd21, 32'hA1, 1, 0, 9'h11, 32'hB1, 0, 0);
    chk("full_drop3", 64'(drop_cnt), 3);
    chk("full_count2", 64'(count), 16);

    // pop-through while full
    exp_e(2'b01, 9'd22, 32'hCC);
    ev(1, 5'd22, 32'hCC, 0, 0, 0, 0, 0, 1);
    chk("pt_count", 64'(count), 16);
    chk("pt_drop", 64'(drop_cnt), 3);
    drain(16);
    chk("pt_drained", 64'(count), 0);
    chk("pt_ovf_sticky", 64'(overflow), 1);

    // 40 alternating events through the wrap
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        exp_e(2'b01, 9'((i % 31) + 1),
              32'h1000 + 32'(i));
        ev(1, 5'((i % 31) + 1),
           32'h1000 + 32'(i),
           0, 0, 0, 0, 0, 1);
      end else begin
        exp_e(2'b10, 9'(i * 7),
              32'h2000 + 32'(i));
        ev(0, 0, 0, 1, 0, 9'(i * 7),
           32'h2000 + 32'(i), 0, 0);
      end
      idle(1'b1);
    end
    drain(4);
    chk("wrap_count", 64'(count), 0);
    chk("wrap_q", 64'(q.size()), 0);

    // clear with events present
    for (int i = 0; i < 3; i++)
      ev(1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    ev(1, 5'd9, 32'h98, 1, 0, 9'h5, 32'h5, 0, 0);
    chk("clr_count", 64'(count), 0);
    chk("clr_valid", 64'(out_valid), 0);
    chk("clr_ovf", 64'(overflow), 0);
    chk("clr_drop", 64'(drop_cnt), 0);
    chk("clr_type", 64'(out_type), 0);

    // saturate the 4-bit drop counter
    for (int i = 0; i < 16; i++) begin
      exp_e(2'b10, 9'(i), 32'h3000 + 32'(i));
      ev(0, 0, 0, 1, 0, 9'(i),
         32'h3000 + 32'(i), 0, 0);
    end
    for (int i = 0; i < 7; i++)
      ev(1, 5'd1, 0, 1, 0, 0, 0, 0, 0);
    chk("sat_drop14", 64'(drop_cnt), 14);
    ev(1, 5'd1, 0, 1, 0, 0, 0, 0, 0);
    chk("sat_drop15", 64'(drop_cnt), 15);
    ev(1, 5'd1, 0, 1, 0, 0, 0, 0, 0);
    chk("sat_hold", 64'(drop_cnt), 15);
    chk("sat_ovf", 64'(overflow), 1);
    drain(16);
    chk("end_count", 64'(count), 0);
    chk("end_q", 64'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
